// File: rtl/ks_pkg.sv
// Shared encodings for the Karplus-Strong pluck sequencer: FSM states,
// step-table field positions and default tick constants.
package ks_pkg;

  localparam int STEP_W     = 8;
  localparam int ADDR_W     = 3;

  localparam int REST_BIT   = 7;
  localparam int ACCENT_BIT = 6;
  localparam int RSVD_MSB   = 5;
  localparam int RSVD_LSB   = 4;
  localparam int PERIOD_MSB = 3;
  localparam int PERIOD_LSB = 0;

  localparam int DEF_SETTLE_TICKS = 2;
  localparam int DEF_PLUCK_TICKS  = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    PLUCK,
    HOLD
  } ksState_t;

  // Wraps to 0 at or past the loop end, so a lowered loop end takes effect at once.
  function automatic logic [ADDR_W-1:0] nextStep(input logic [ADDR_W-1:0] cur,
                                                 input logic [ADDR_W-1:0] last);
    return (cur >= last) ? '0 : cur + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/ks_step_ram.sv
// Step table: register file with one synchronous write port and one
// asynchronous read port, cleared by reset.
module ks_step_ram
  import ks_pkg::*;
#(
  parameter int NUM_STEPS = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [STEP_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [STEP_W-1:0] rdata_o
);

  logic [STEP_W-1:0] mem_q [NUM_STEPS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ks_pluck_sequencer.sv
// Step sequencer driving a Karplus-Strong string: loads a period per step,
// waits a settle time, plucks, then holds until the tempo count expires.
module ks_pluck_sequencer
  import ks_pkg::*;
#(
  parameter int NUM_STEPS    = 8,
  parameter int PERIOD_W     = 4,
  parameter int TEMPO_W      = 16,
  parameter int SETTLE_TICKS = DEF_SETTLE_TICKS,
  parameter int PLUCK_TICKS  = DEF_PLUCK_TICKS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
  input  logic                run_i,
  input  logic                step_we_i,
  input  logic [ADDR_W-1:0]   step_addr_i,
  input  logic [STEP_W-1:0]   step_data_i,
  input  logic [TEMPO_W-1:0]  tempo_i,
  input  logic [ADDR_W-1:0]   loop_last_i,
  output logic                pluck_o,
  output logic [PERIOD_W-1:0] period_o,
  output logic                accent_o,
  output logic [ADDR_W-1:0]   step_o,
  output logic                busy_o
);

  localparam logic [TEMPO_W-1:0] SETTLE_END = TEMPO_W'(SETTLE_TICKS);
  localparam logic [TEMPO_W-1:0] PLUCK_END  = TEMPO_W'(SETTLE_TICKS + PLUCK_TICKS);

  ksState_t            state_q, state_d;
  logic [TEMPO_W-1:0]  tempoCnt_q, tempoCnt_d;
  logic [ADDR_W-1:0]   stepIdx_q, stepIdx_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                accent_q, accent_d;
  logic                rest_q, rest_d;

  logic [STEP_W-1:0]   entry;
  logic [TEMPO_W-1:0]  cntInc;
  logic [TEMPO_W-1:0]  stepLen;
  logic                unusedRsvd;

  ks_step_ram #(
    .NUM_STEPS (NUM_STEPS)
  ) u_step_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (step_we_i),
    .waddr_i (step_addr_i),
    .wdata_i (step_data_i),
    .raddr_i (stepIdx_q),
    .rdata_o (entry)
  );

  assign unusedRsvd = ^entry[RSVD_MSB:RSVD_LSB];
  assign cntInc     = tempoCnt_q + TEMPO_W'(1);
  // A step can never be shorter than settle plus pluck, so tempo 0 means "as fast as possible".
  assign stepLen    = (tempo_i > PLUCK_END) ? tempo_i : PLUCK_END;

  always_comb begin
    state_d    = state_q;
    tempoCnt_d = tempoCnt_q;
    stepIdx_d  = stepIdx_q;
    period_d   = period_q;
    accent_d   = accent_q;
    rest_d     = rest_q;
    if (state_q != IDLE && !run_i) begin
      state_d    = IDLE;
      stepIdx_d  = '0;
      tempoCnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run_i) state_d = LOAD;
        end
        LOAD: begin
          rest_d = entry[REST_BIT];
          if (!entry[REST_BIT]) begin
            period_d = PERIOD_W'(entry[PERIOD_MSB:PERIOD_LSB]);
            accent_d = entry[ACCENT_BIT];
          end
          tempoCnt_d = '0;
          state_d    = SETTLE;
        end
        SETTLE: begin
          if (tick_i) begin
            tempoCnt_d = cntInc;
            if (cntInc >= SETTLE_END) state_d = rest_q ? HOLD : PLUCK;
          end
        end
        PLUCK: begin
          if (tick_i) begin
            tempoCnt_d = cntInc;
            if (cntInc >= PLUCK_END) state_d = HOLD;
          end
        end
        HOLD: begin
          if (tempoCnt_q >= stepLen) begin
            stepIdx_d = nextStep(stepIdx_q, loop_last_i);
            state_d   = LOAD;
          end else if (tick_i) begin
            tempoCnt_d = cntInc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      tempoCnt_q <= '0;
      stepIdx_q  <= '0;
      period_q   <= '0;
      accent_q   <= 1'b0;
      rest_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tempoCnt_q <= tempoCnt_d;
      stepIdx_q  <= stepIdx_d;
      period_q   <= period_d;
      accent_q   <= accent_d;
      rest_q     <= rest_d;
    end
  end

  assign pluck_o  = (state_q == PLUCK);
  assign busy_o   = (state_q != IDLE);
  assign period_o = period_q;
  assign accent_o = accent_q;
  assign step_o   = stepIdx_q;

endmodule

// File: tb/tb_ks_pluck_sequencer.sv
// Directed scenarios plus a randomized run, each cycle compared against a
// tick-counting reference model of the sequencer.
module tb_ks_pluck_sequencer;

  localparam int SETTLE = 2;
  localparam int PLUCK  = 4;

  logic        clk = 1'b0;
  logic        rst_i, tick_i, run_i, step_we_i;
  logic [2:0]  step_addr_i, loop_last_i;
  logic [7:0]  step_data_i;
  logic [15:0] tempo_i;
  logic        pluck_o, accent_o, busy_o;
  logic [3:0]  period_o;
  logic [2:0]  step_o;

  int checks = 0;
  int errors = 0;

  // reference model: a step is "ticks counted since load"; the pluck window and
  // step end follow directly from that count
  logic       mBusy, mLoading, mRest, mAccent;
  int         mStep, mCnt, mPeriod;
  logic [7:0] mTable [8];

  int tickPeriod, tickPhase;
  int tickCount, pluckCount, stepLen, stepPluck, changes;

  always #5 clk = ~clk;

  ks_pluck_sequencer dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .tick_i      (tick_i),
    .run_i       (run_i),
    .step_we_i   (step_we_i),
    .step_addr_i (step_addr_i),
    .step_data_i (step_data_i),
    .tempo_i     (tempo_i),
    .loop_last_i (loop_last_i),
    .pluck_o     (pluck_o),
    .period_o    (period_o),
    .accent_o    (accent_o),
    .step_o      (step_o),
    .busy_o      (busy_o)
  );

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic expPluck;
    expPluck = mBusy && !mLoading && !mRest && (mCnt >= SETTLE) && (mCnt < SETTLE + PLUCK);
    checkValue("pluck", 32'(pluck_o), 32'(expPluck));
    checkValue("busy", 32'(busy_o), 32'(mBusy));
    checkValue("step", 32'(step_o), mStep);
    checkValue("period", 32'(period_o), mPeriod);
    checkValue("accent", 32'(accent_o), 32'(mAccent));
  endtask

  task automatic modelUpdate();
    logic [7:0] e;
    int lim;
    if (rst_i) begin
      mBusy = 0; mLoading = 0; mRest = 0; mAccent = 0;
      mStep = 0; mCnt = 0; mPeriod = 0;
      foreach (mTable[i]) mTable[i] = '0;
    end else begin
      lim = (int'(tempo_i) > SETTLE + PLUCK) ? int'(tempo_i) : SETTLE + PLUCK;
      if (!mBusy) begin
        if (run_i) begin mBusy = 1; mLoading = 1; end
      end else if (!run_i) begin
        mBusy = 0; mLoading = 0; mStep = 0; mCnt = 0;
      end else if (mLoading) begin
        e = mTable[mStep];
        mRest = e[7];
        if (!e[7]) begin mPeriod = int'(e[3:0]); mAccent = e[6]; end
        mCnt = 0;
        mLoading = 0;
      end else if (mCnt >= lim) begin
        mStep = (mStep >= int'(loop_last_i)) ? 0 : mStep + 1;
        mLoading = 1;
      end else if (tick_i) begin
        mCnt++;
      end
      if (step_we_i) mTable[step_addr_i] = step_data_i;
    end
  endtask

  task automatic applyStimulus(input int n);
    logic [2:0] prevStep;
    for (int k = 0; k < n; k++) begin
      if (tickPeriod > 0) begin
        tick_i = (tickPhase == tickPeriod - 1);
        tickPhase = (tickPhase + 1) % tickPeriod;
      end else begin
        tick_i = ($urandom_range(0, 1) == 1);
      end
      prevStep = step_o;
      if (tick_i) tickCount++;
      if (tick_i && pluck_o === 1'b1) pluckCount++;
      modelUpdate();
      @(posedge clk);
      @(negedge clk);
      if (step_o !== prevStep) begin
        stepLen = tickCount; stepPluck = pluckCount;
        tickCount = 0; pluckCount = 0;
        changes++;
      end
      checkOutput();
    end
  endtask

  task automatic writeEntry(input logic [2:0] addr, input logic [7:0] data);
    step_we_i = 1'b1; step_addr_i = addr; step_data_i = data;
    applyStimulus(1);
    step_we_i = 1'b0;
  endtask

  task automatic waitStepChange(input string tag, input int maxCycles);
    int startChanges, n;
    startChanges = changes; n = 0;
    while (changes == startChanges && n < maxCycles) begin
      applyStimulus(1); n++;
    end
    checks++;
    assert (changes != startChanges) else begin
      errors++;
      $error("[TB] FAIL %s timeout observed no step change expected one within %0d cycles", tag, maxCycles);
    end
  endtask

  task automatic restartScenario();
    run_i = 1'b0;
    applyStimulus(2);
    tickPhase = 0; tickCount = 0; pluckCount = 0;
  endtask

  initial begin
    int n;
    logic sawPluck;
    rst_i = 1'b1; tick_i = 1'b0; run_i = 1'b0; step_we_i = 1'b0;
    step_addr_i = '0; step_data_i = '0; tempo_i = 16'd10; loop_last_i = 3'd1;
    tickPeriod = 16; tickPhase = 0;
    tickCount = 0; pluckCount = 0; stepLen = 0; stepPluck = 0; changes = 0;
    applyStimulus(3);
    rst_i = 1'b0;
    checkValue("rst_pluck", 32'(pluck_o), 0);
    checkValue("rst_busy", 32'(busy_o), 0);
    checkValue("rst_step", 32'(step_o), 0);
    checkValue("rst_period", 32'(period_o), 0);
    checkValue("rst_accent", 32'(accent_o), 0);

    $display("[TB] scenario 1: two-step loop, tempo 10");
    writeEntry(3'd0, 8'h05);
    writeEntry(3'd1, 8'h4A);
    restartScenario();
    run_i = 1'b1;
    waitStepChange("s1_first", 400);
    checkValue("s1_step1", 32'(step_o), 1);
    checkValue("s1_len0", stepLen, 10);
    checkValue("s1_pluck0", stepPluck, 4);
    checkValue("s1_period0", 32'(period_o), 5);
    applyStimulus(2);
    checkValue("s1_period1", 32'(period_o), 10);
    checkValue("s1_accent1", 32'(accent_o), 1);
    waitStepChange("s1_wrap", 400);
    checkValue("s1_wrap_step", 32'(step_o), 0);
    checkValue("s1_len1", stepLen, 10);
    checkValue("s1_pluck1", stepPluck, 4);

    $display("[TB] scenario 2: rest step");
    restartScenario();
    writeEntry(3'd0, 8'h80);
    tickPhase = 0; tickCount = 0; pluckCount = 0;
    run_i = 1'b1;
    waitStepChange("s2_rest", 400);
    checkValue("s2_len", stepLen, 10);
    checkValue("s2_pluck", stepPluck, 0);
    checkValue("s2_period_kept", 32'(period_o), 10);

    $display("[TB] scenario 3: tempo 0");
    restartScenario();
    writeEntry(3'd0, 8'h07);
    tempo_i = 16'd0;
    tickPhase = 0; tickCount = 0; pluckCount = 0;
    run_i = 1'b1;
    waitStepChange("s3_first", 400);
    waitStepChange("s3_second", 400);
    checkValue("s3_len", stepLen, 6);
    checkValue("s3_pluck", stepPluck, 4);

    $display("[TB] scenario 4: stop during pluck");
    tempo_i = 16'd10;
    n = 0;
    while (!(pluck_o === 1'b1 && step_o == 3'd1) && n < 600) begin applyStimulus(1); n++; end
    checkValue("s4_found_pluck", 32'(pluck_o), 1);
    run_i = 1'b0;
    applyStimulus(1);
    checkValue("s4_pluck", 32'(pluck_o), 0);
    checkValue("s4_busy", 32'(busy_o), 0);
    checkValue("s4_step", 32'(step_o), 0);
    checkValue("s4_period_kept", 32'(period_o), 10);

    $display("[TB] scenario 5: write playing entry during hold");
    restartScenario();
    run_i = 1'b1;
    sawPluck = 1'b0; n = 0;
    while (!(sawPluck && pluck_o === 1'b0 && busy_o === 1'b1 && step_o == 3'd0) && n < 600) begin
      applyStimulus(1); n++;
      if (pluck_o === 1'b1 && step_o == 3'd0) sawPluck = 1'b1;
    end
    checkValue("s5_found_hold", 32'(sawPluck), 1);
    writeEntry(3'd0, 8'h03);
    checkValue("s5_period_hold", 32'(period_o), 7);
    waitStepChange("s5_to1", 400);
    checkValue("s5_period_step0_end", 32'(period_o), 7);
    applyStimulus(2);
    waitStepChange("s5_to0", 400);
    applyStimulus(2);
    checkValue("s5_period_new", 32'(period_o), 3);

    $display("[TB] scenario 6: reset during pluck");
    n = 0;
    while (pluck_o !== 1'b1 && n < 600) begin applyStimulus(1); n++; end
    checkValue("s6_found_pluck", 32'(pluck_o), 1);
    rst_i = 1'b1;
    applyStimulus(1);
    rst_i = 1'b0;
    checkValue("s6_pluck", 32'(pluck_o), 0);
    checkValue("s6_busy", 32'(busy_o), 0);
    checkValue("s6_step", 32'(step_o), 0);
    checkValue("s6_period", 32'(period_o), 0);
    checkValue("s6_accent", 32'(accent_o), 0);
    loop_last_i = 3'd7; tempo_i = 16'd0; tickPeriod = 0;
    applyStimulus(300);
    checkValue("s6_table_period", 32'(period_o), 0);
    checkValue("s6_table_accent", 32'(accent_o), 0);

    $display("[TB] randomized run");
    for (int c = 0; c < 3000; c++) begin
      rst_i = ($urandom_range(0, 499) == 0);
      step_we_i = ($urandom_range(0, 7) == 0);
      step_addr_i = 3'($urandom_range(0, 7));
      step_data_i = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 63) == 0) run_i = ~run_i;
      else if (!run_i && $urandom_range(0, 7) == 0) run_i = 1'b1;
      if ($urandom_range(0, 49) == 0) tempo_i = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 39) == 0) loop_last_i = 3'($urandom_range(0, 7));
      applyStimulus(1);
    end
    rst_i = 1'b0; step_we_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ks_pluck_sequencer.md
KS_PLUCK_SEQUENCER -- requirements
Module: ks_pluck_sequencer

Interface
REQ-001 SHALL have parameters (one per line: name, default, meaning):
- NUM_STEPS, 8, entries in the step table.
- PERIOD_W, 4, width of the KS period field.
- TEMPO_W, 16, tempo counter width.
- SETTLE_TICKS, 2, ticks between period update and pluck.
- PLUCK_TICKS, 4, ticks pluck_o is held.
REQ-002 SHALL have ports (one per line: name, direction, width, meaning):
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- tick_i  in  1  one-cycle sample-rate enable; all tick counts refer to cycles with tick_i=1.
- run_i  in  1  level; 1 = sequence plays.
- step_we_i  in  1  step-table write strobe.
- step_addr_i  in  3  step-table write address.
- step_data_i  in  8  {rest[7], accent[6], rsvd[5:4], period[3:0]}.
- tempo_i  in  TEMPO_W  step length in ticks.
- loop_last_i  in  3  index of last step before wrap.
- pluck_o  out  1  pluck level to the KS string.
- period_o  out  PERIOD_W  KS period.
- accent_o  out  1  dynamics enable for the current note.
- step_o  out  3  index of current step.
- busy_o  out  1  1 whenever state is not IDLE.

Function
REQ-003 SHALL hold a NUM_STEPS x 8-bit step table, written on step_we_i at step_addr_i in the same cycle, regardless of state.
REQ-004 SHALL implement states IDLE, LOAD, SETTLE, PLUCK and HOLD.
REQ-005 IDLE->LOAD SHALL occur on the first cycle with run_i=1.
REQ-006 LOAD SHALL last exactly one clk_i cycle:
- latch period_o and accent_o from table[step_o], unless the entry's rest bit is 1;
- clear the tempo counter;
- go to SETTLE.
REQ-007 SETTLE SHALL count SETTLE_TICKS ticks, then go to PLUCK; for a rest step it SHALL go to HOLD instead.
REQ-008 PLUCK SHALL assert pluck_o for exactly PLUCK_TICKS ticks, then go to HOLD; pluck_o SHALL be 0 in every other state.
REQ-009 The tempo counter SHALL increment on every tick from LOAD exit onward.
REQ-010 HOLD SHALL exit when the count reaches max(tempo_i, SETTLE_TICKS+PLUCK_TICKS), so tempo_i=0 gives the minimum step length.
REQ-011 On HOLD exit, step_o SHALL become 0 if step_o >= loop_last_i, else step_o+1, and the state SHALL go to LOAD.
REQ-012 run_i=0 in any non-IDLE state SHALL force IDLE on the next edge:
- pluck_o=0 and step_o=0;
- period_o and accent_o retained.
REQ-013 A write to the entry currently playing SHALL NOT change period_o/accent_o until that entry is next loaded.
REQ-014 A change to tempo_i or loop_last_i SHALL take effect at the next comparison; lowering loop_last_i below step_o SHALL cause a wrap to 0 at the next advance.
REQ-015 Ticks SHALL be counted only when tick_i=1; with tick_i held 0, all states except LOAD SHALL stall.

Reset
REQ-016 rst_i=1 SHALL synchronously set:
- state=IDLE, step_o=0, pluck_o=0, period_o=0, accent_o=0;
- counters=0, table entries=0.
REQ-017 Reset SHALL take priority over run_i and step_we_i, including mid-PLUCK.

Structure
REQ-018 The state encoding, step_data field positions and default SETTLE/PLUCK tick constants SHALL live in a shared package, ks_pkg.
REQ-019 The step table SHALL be one sub-module, ks_step_ram: register file, 1 write port, 1 asynchronous read port.

Verification
REQ-020 Scenario 1: table[0]=0x05, table[1]=0x4A, loop_last=1, tempo=10, tick every 16 clocks, run=1 -> period_o=5, pluck_o high ticks 2..5, step_o=1 at tick 10, period_o=10 and accent_o=1, step_o wraps to 0 at tick 20.
REQ-021 Scenario 2: table[0]=0x80 (rest) -> pluck_o stays 0 for the whole step; step length is still 10 ticks.
REQ-022 Scenario 3: tempo_i=0 -> step lasts 6 ticks.
REQ-023 Scenario 4: run_i dropped during PLUCK -> next cycle pluck_o=0, busy_o=0, step_o=0.
REQ-024 Scenario 5: write table[step_o]=0x03 during HOLD -> period_o unchanged until the next loop pass.
REQ-025 Scenario 6: rst_i pulsed mid-PLUCK -> all outputs 0 the next cycle; table reads back 0.
